// File: rtl/regfile_pkg.sv
// Shared register file types and sizes, used by the writeback controller and the regfile itself.
package regfile_pkg;
   localparam int DATA_W = 36;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

   // Writeback source identity; also the round-robin pointer encoding.
   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_t;
endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter: combinational grant (0 cycles), pointer flop passes priority to the
// loser after each grant; a requester that is not granted simply waits with its request held.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);
   src_t ptr_q, ptr_d;

   always_comb begin
      gnt   = req;
      ptr_d = ptr_q;
      if (req == 2'b11) begin
         gnt = (ptr_q == SRC_ALU) ? 2'b01 : 2'b10;
      end
      if (gnt[0]) begin
         ptr_d = SRC_MEM;
      end else if (gnt[1]) begin
         ptr_d = SRC_ALU;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= SRC_ALU;
      end else begin
         ptr_q <= ptr_d;
      end
   end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register file write-port owner: arbitrates ALU/load writebacks (1 reg stage, data stored 2 edges
// after handshake), tracks busy registers for RAW queries and stalls issue on WAW via issue_ready.
module regfile_wb_ctrl
   import regfile_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] q1_addr,
   input  logic [ADDR_W-1:0] q2_addr,
   output logic              q1_busy,
   output logic              q2_busy,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data
);
   logic [1:0]      gnt;
   logic            wb_hs;
   reg_addr_t       wb_addr;
   reg_data_t       wb_data;

   logic [NREG-1:0] busy_q, busy_d;
   logic            we_q, we_d;
   reg_addr_t       waddr_q, waddr_d;
   reg_data_t       wdata_q, wdata_d;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({mem_valid, alu_valid}),
      .gnt   (gnt)
   );

   assign alu_ready = gnt[0];
   assign mem_ready = gnt[1];
   assign wb_hs     = |gnt;
   assign wb_addr   = gnt[1] ? mem_addr : alu_addr;
   assign wb_data   = gnt[1] ? mem_data : alu_data;

   assign issue_ready = (issue_addr == '0) | ~busy_q[issue_addr];

   // The pending-write term covers the commit edge, where a registered read still sees old data.
   assign q1_busy = (q1_addr != '0) & (busy_q[q1_addr] | (we_q & (waddr_q == q1_addr)));
   assign q2_busy = (q2_addr != '0) & (busy_q[q2_addr] | (we_q & (waddr_q == q2_addr)));

   always_comb begin
      busy_d  = busy_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (wb_hs) begin
         busy_d[wb_addr] = 1'b0;
         we_d            = (wb_addr != '0);
         waddr_d         = wb_addr;
         wdata_d         = wb_data;
      end
      if (issue_valid && issue_ready && (issue_addr != '0)) begin
         busy_d[issue_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         busy_q  <= busy_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign write_enable = we_q;
   assign write_addr   = waddr_q;
   assign write_data   = wdata_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wb_ctrl;
   import regfile_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              alu_valid, alu_ready, mem_valid, mem_ready;
   logic [ADDR_W-1:0] alu_addr, mem_addr, issue_addr, q1_addr, q2_addr, write_addr;
   logic [DATA_W-1:0] alu_data, mem_data, write_data;
   logic              issue_valid, issue_ready, q1_busy, q2_busy, write_enable;

   regfile_wb_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
      .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a set of claimed registers, the last write-port contents, and who has priority.
   bit [NREG-1:0]     m_busy;
   bit                m_we;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   int                m_prio;   // 0 = ALU wins a tie, 1 = MEM wins a tie

   task automatic m_reset();
      m_busy = '0; m_we = 0; m_waddr = '0; m_wdata = '0; m_prio = 0;
   endtask

   // Winner this cycle: -1 none, 0 ALU, 1 MEM.
   function automatic int m_grant();
      if (alu_valid && mem_valid) return m_prio;
      if (alu_valid) return 0;
      if (mem_valid) return 1;
      return -1;
   endfunction

   function automatic bit m_issue_ok(input logic [ADDR_W-1:0] a);
      return (a == 0) || !m_busy[a];
   endfunction

   function automatic bit m_qbusy(input logic [ADDR_W-1:0] a);
      return (a != 0) && (m_busy[a] || (m_we && m_waddr == a));
   endfunction

   // Advance the model by one clock edge using the inputs currently applied, then step the DUT.
   task automatic tick();
      int                g;
      bit [NREG-1:0]     nb;
      bit                nwe;
      logic [ADDR_W-1:0] na;
      logic [DATA_W-1:0] nd;
      g = m_grant(); nb = m_busy; nwe = 0; na = m_waddr; nd = m_wdata;
      if (g >= 0) begin
         na = (g == 0) ? alu_addr : mem_addr;
         nd = (g == 0) ? alu_data : mem_data;
         nwe = (na != 0);
         if (na != 0) nb[na] = 0;
         m_prio = 1 - g;
      end
      if (issue_valid && m_issue_ok(issue_addr) && issue_addr != 0) nb[issue_addr] = 1;
      @(posedge clk);
      m_busy = nb; m_we = nwe; m_waddr = na; m_wdata = nd;
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 0; mem_valid = 0; issue_valid = 0;
      alu_addr = '0; mem_addr = '0; issue_addr = '0;
      alu_data = '0; mem_data = '0; q1_addr = '0; q2_addr = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      m_reset();
      #12;
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", write_enable); end
      checks++; if (write_addr !== '0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", write_addr); end
      checks++; if (write_data !== '0) begin errors++; $display("FAIL reset_wdata got %h exp 0", write_data); end
      issue_addr = 5'd5; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
      rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_issue_claim();
      issue_valid = 1; issue_addr = 5'd5; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL claim_first_ready got %b exp 1", issue_ready); end
      tick();
      q1_addr = 5'd5; #1;
      checks++; if (q1_busy !== 1'b1) begin errors++; $display("FAIL claim_q1_busy got %b exp 1", q1_busy); end
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL claim_waw_block got %b exp 0", issue_ready); end
      tick();
      issue_valid = 0;
   endtask

   task automatic test_alu_write();
      alu_valid = 1; alu_addr = 5'd5; alu_data = 36'hABCDE0123; #1;
      checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL alu_ready got %b/%b exp 1/0", alu_ready, mem_ready); end
      tick();
      alu_valid = 0; issue_addr = 5'd5; q1_addr = 5'd5; #1;
      checks++; if (write_enable !== 1'b1 || write_addr !== 5'd5 || write_data !== 36'hABCDE0123) begin
         errors++; $display("FAIL alu_wport got %b %0d %h exp 1 5 abcde0123", write_enable, write_addr, write_data); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL alu_busy_cleared got issue_ready %b exp 1", issue_ready); end
      checks++; if (q1_busy !== 1'b1) begin errors++; $display("FAIL alu_pending_q1 got %b exp 1", q1_busy); end
      tick(); #1;
      checks++; if (q1_busy !== 1'b0 || write_enable !== 1'b0) begin errors++; $display("FAIL alu_committed got q1 %b we %b exp 0 0", q1_busy, write_enable); end
   endtask

   task automatic test_rr_arb();
      int g;
      alu_valid = 1; alu_addr = 5'd3; alu_data = 36'h111111111;
      mem_valid = 1; mem_addr = 5'd4; mem_data = 36'h222222222;
      for (int c = 0; c < 4; c++) begin
         #1;
         g = m_grant();
         checks++; if (alu_ready !== (g == 0) || mem_ready !== (g == 1)) begin
            errors++; $display("FAIL rr_grant cyc %0d got %b/%b exp %b/%b", c, alu_ready, mem_ready, g == 0, g == 1); end
         checks++; if (alu_ready && mem_ready) begin errors++; $display("FAIL rr_both_ready cyc %0d got 1/1 exp one-hot", c); end
         tick();
         checks++; if (write_enable !== m_we || write_addr !== m_waddr || write_data !== m_wdata) begin
            errors++; $display("FAIL rr_wport cyc %0d got %b %0d %h exp %b %0d %h", c, write_enable, write_addr, write_data, m_we, m_waddr, m_wdata); end
      end
      alu_valid = 0; mem_valid = 0;
      tick();
   endtask

   task automatic test_reg0();
      mem_valid = 1; mem_addr = 5'd0; mem_data = 36'hFFFFFFFFF; #1;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reg0_ready got %b exp 1", mem_ready); end
      tick();
      mem_valid = 0; q1_addr = 5'd0; #1;
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reg0_we got %b exp 0", write_enable); end
      checks++; if (q1_busy !== 1'b0) begin errors++; $display("FAIL reg0_q1 got %b exp 0", q1_busy); end
   endtask

   task automatic test_set_clear();
      issue_valid = 1; issue_addr = 5'd9; tick();
      issue_addr = 5'd7; alu_valid = 1; alu_addr = 5'd9; alu_data = 36'h0DEADBEEF; tick();
      issue_valid = 0; alu_valid = 0; issue_addr = 5'd7; #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL setclr_set7 got issue_ready %b exp 0", issue_ready); end
      issue_addr = 5'd9; #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL setclr_clr9 got issue_ready %b exp 1", issue_ready); end
      tick();
   endtask

   task automatic test_reset_mid();
      issue_valid = 1; issue_addr = 5'd2; tick();
      issue_addr = 5'd6; alu_valid = 1; alu_addr = 5'd11; alu_data = 36'h123456789; tick();
      issue_valid = 0; alu_valid = 0; q1_addr = 5'd2; q2_addr = 5'd6; issue_addr = 5'd6;
      #1 rst_n = 0;
      m_reset();
      #1;
      checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b exp 0", write_enable); end
      checks++; if (q1_busy !== 1'b0 || q2_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b/%b exp 0/0", q1_busy, q2_busy); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_issue got %b exp 1", issue_ready); end
      #1 rst_n = 1;
      @(negedge clk);
      alu_valid = 1; mem_valid = 1; alu_addr = 5'd1; mem_addr = 5'd2; #1;
      checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ptr got %b/%b exp 1/0", alu_ready, mem_ready); end
      tick();
      alu_valid = 0; mem_valid = 0;
      tick();
   endtask

   task automatic test_random();
      int          g;
      logic [63:0] r;
      g = -1;
      for (int c = 0; c < 400; c++) begin
         // A source left waiting must keep its request unchanged.
         if (!(alu_valid && g != 0)) begin
            alu_valid = 1'($urandom_range(0, 1)); alu_addr = 5'($urandom_range(0, 7));
            r = {$urandom, $urandom}; alu_data = r[DATA_W-1:0];
         end
         if (!(mem_valid && g != 1)) begin
            mem_valid = 1'($urandom_range(0, 1)); mem_addr = 5'($urandom_range(0, 7));
            r = {$urandom, $urandom}; mem_data = r[DATA_W-1:0];
         end
         issue_valid = 1'($urandom_range(0, 1)); issue_addr = 5'($urandom_range(0, 7));
         q1_addr = 5'($urandom_range(0, 7)); q2_addr = 5'($urandom_range(0, 7));
         #1;
         g = m_grant();
         checks++; if (alu_ready !== (g == 0) || mem_ready !== (g == 1)) begin
            errors++; $display("FAIL rand_grant cyc %0d got %b/%b exp %b/%b", c, alu_ready, mem_ready, g == 0, g == 1); end
         checks++; if (issue_ready !== m_issue_ok(issue_addr)) begin
            errors++; $display("FAIL rand_issue cyc %0d addr %0d got %b exp %b", c, issue_addr, issue_ready, m_issue_ok(issue_addr)); end
         checks++; if (q1_busy !== m_qbusy(q1_addr) || q2_busy !== m_qbusy(q2_addr)) begin
            errors++; $display("FAIL rand_query cyc %0d got %b/%b exp %b/%b", c, q1_busy, q2_busy, m_qbusy(q1_addr), m_qbusy(q2_addr)); end
         checks++; if (write_enable !== m_we || (m_we && (write_addr !== m_waddr || write_data !== m_wdata))) begin
            errors++; $display("FAIL rand_wport cyc %0d got %b %0d %h exp %b %0d %h", c, write_enable, write_addr, write_data, m_we, m_waddr, m_wdata); end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      test_reset();
      test_issue_claim();
      test_alu_write();
      test_rr_arb();
      test_reg0();
      test_set_clear();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
